// File: rtl/tx_package.sv
// Shared parameters, output format and commit-FSM encoding for the TX feed-forward equalizer.
package tx_package;

  localparam int N_FFE_TAPS      = 3;
  localparam int FFE_COEFF_WIDTH = 10;
  localparam int FFE_OUT_WIDTH   = 14;

  typedef logic signed [FFE_OUT_WIDTH-1:0] FFE_OUT_FORMAT;

  typedef enum logic [0:0] {
    COMMIT_IDLE    = 1'b0,
    COMMIT_PENDING = 1'b1
  } commit_state_e;

endpackage

// File: rtl/my_dff.sv
// Plain register with synchronous active-high reset; enables are built by the caller.
module my_dff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= {WIDTH{1'b0}};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/tx_ffe_sum.sv
// Combinational adder of the signed FFE terms with saturation to the output width.
module tx_ffe_sum
  import tx_package::*;
#(
  parameter int N_TAPS     = N_FFE_TAPS,
  parameter int TERM_WIDTH = FFE_COEFF_WIDTH + 1,
  parameter int SUM_WIDTH  = FFE_COEFF_WIDTH + 3,
  parameter int OUT_WIDTH  = FFE_OUT_WIDTH
) (
  input  logic        [N_TAPS-1:0][TERM_WIDTH-1:0] terms,
  output logic signed [OUT_WIDTH-1:0]              sum_sat
);

  localparam int EXT_WIDTH = (OUT_WIDTH > SUM_WIDTH) ? OUT_WIDTH : SUM_WIDTH;
  localparam int HI_WIDTH  = EXT_WIDTH - OUT_WIDTH + 1;

  logic signed [SUM_WIDTH-1:0] sum_s;
  logic signed [EXT_WIDTH-1:0] wide_s;
  logic        [HI_WIDTH-1:0]  hi_s;

  // full-precision sum of sign-extended terms
  always_comb begin
    sum_s = {SUM_WIDTH{1'b0}};
    for (int k = 0; k < N_TAPS; k++) begin
      sum_s = sum_s + {{(SUM_WIDTH-TERM_WIDTH){terms[k][TERM_WIDTH-1]}}, terms[k]};
    end
  end

  // the value fits when every bit above the output sign bit matches it
  always_comb begin
    wide_s = EXT_WIDTH'(sum_s);
    hi_s   = wide_s[EXT_WIDTH-1:OUT_WIDTH-1];
    if ((hi_s == {HI_WIDTH{1'b0}}) || (hi_s == {HI_WIDTH{1'b1}})) begin
      sum_sat = wide_s[OUT_WIDTH-1:0];
    end else if (wide_s[EXT_WIDTH-1]) begin
      sum_sat = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    end else begin
      sum_sat = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/tx_ffe.sv
// Transmit FFE: +/-1 symbol history weighted by a double-buffered tap set, two-stage pipeline.
module tx_ffe
  import tx_package::*;
#(
  parameter int N_TAPS      = N_FFE_TAPS,
  parameter int COEFF_WIDTH = FFE_COEFF_WIDTH,
  parameter int OUT_WIDTH   = FFE_OUT_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in,
  input  logic                         in_valid,
  input  logic                         coeff_wr_en,
  input  logic [$clog2(N_TAPS)-1:0]    coeff_wr_addr,
  input  logic signed [COEFF_WIDTH-1:0] coeff_wr_data,
  input  logic                         coeff_commit,
  output logic                         commit_done,
  output logic                         coeff_err,
  output logic signed [OUT_WIDTH-1:0]  out,
  output logic                         out_valid
);

  localparam int TERM_WIDTH = COEFF_WIDTH + 1;
  localparam int SUM_WIDTH  = COEFF_WIDTH + $clog2(N_TAPS) + 1;

  commit_state_e state_r, state_next_s;
  logic swap_s, wr_drop_s, wr_accept_s;

  logic [N_TAPS-2:0] hist_r, hist_next_s;
  logic [N_TAPS-1:0] win_s;

  logic [N_TAPS-1:0][COEFF_WIDTH-1:0] shadow_r, active_r, coeff_sel_s;
  logic [N_TAPS-1:0][TERM_WIDTH-1:0]  terms_s, terms_r;
  logic                               valid1_r;
  logic signed [OUT_WIDTH-1:0]        sum_sat_s;

  // bit k of the window is symbol n-k; history only advances on accepted symbols
  assign win_s       = {hist_r, in};
  assign hist_next_s = in_valid ? win_s[N_TAPS-2:0] : hist_r;

  my_dff #(.WIDTH(N_TAPS-1)) u_hist (
    .clk (clk),
    .rst (rst),
    .d   (hist_next_s),
    .q   (hist_r)
  );

  // commit FSM next state, swap strobe and write gating
  always_comb begin
    state_next_s = state_r;
    swap_s       = 1'b0;
    wr_drop_s    = 1'b0;
    wr_accept_s  = 1'b0;
    case (state_r)
      COMMIT_IDLE: begin
        wr_accept_s = coeff_wr_en && (int'(coeff_wr_addr) < N_TAPS);
        if (coeff_commit) begin
          state_next_s = COMMIT_PENDING;
        end else begin
          state_next_s = COMMIT_IDLE;
        end
      end
      COMMIT_PENDING: begin
        wr_drop_s = coeff_wr_en;
        if (in_valid) begin
          swap_s       = 1'b1;
          state_next_s = COMMIT_IDLE;
        end else begin
          state_next_s = COMMIT_PENDING;
        end
      end
      default: begin
        state_next_s = COMMIT_IDLE;
      end
    endcase
  end

  // the swapping symbol already sees the shadow bank, so no sample mixes banks
  always_comb begin
    coeff_sel_s = swap_s ? shadow_r : active_r;
    for (int k = 0; k < N_TAPS; k++) begin
      if (win_s[k]) begin
        terms_s[k] = {coeff_sel_s[k][COEFF_WIDTH-1], coeff_sel_s[k]};
      end else begin
        terms_s[k] = {TERM_WIDTH{1'b0}} - {coeff_sel_s[k][COEFF_WIDTH-1], coeff_sel_s[k]};
      end
    end
  end

  // FSM state, coefficient banks and status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= COMMIT_IDLE;
      shadow_r    <= {(N_TAPS*COEFF_WIDTH){1'b0}};
      active_r    <= {(N_TAPS*COEFF_WIDTH){1'b0}};
      commit_done <= 1'b0;
      coeff_err   <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      commit_done <= swap_s;
      coeff_err   <= coeff_err | wr_drop_s;
      if (wr_accept_s) begin
        shadow_r[coeff_wr_addr] <= coeff_wr_data;
      end
      if (swap_s) begin
        active_r <= shadow_r;
      end
    end
  end

  tx_ffe_sum #(
    .N_TAPS     (N_TAPS),
    .TERM_WIDTH (TERM_WIDTH),
    .SUM_WIDTH  (SUM_WIDTH),
    .OUT_WIDTH  (OUT_WIDTH)
  ) u_sum (
    .terms   (terms_r),
    .sum_sat (sum_sat_s)
  );

  // stage 1 holds the signed terms, stage 2 the saturated sum; out holds between symbols
  always_ff @(posedge clk) begin
    if (rst) begin
      terms_r   <= {(N_TAPS*TERM_WIDTH){1'b0}};
      valid1_r  <= 1'b0;
      out       <= {OUT_WIDTH{1'b0}};
      out_valid <= 1'b0;
    end else begin
      valid1_r  <= in_valid;
      out_valid <= valid1_r;
      if (in_valid) begin
        terms_r <= terms_s;
      end
      if (valid1_r) begin
        out <= sum_sat_s;
      end
    end
  end

endmodule

// File: tb/tb_tx_ffe.sv
// Directed bench for tx_ffe: default instance for function/commit behaviour, 10-bit-output instance for saturation.
module tb_tx_ffe;
  import tx_package::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // default instance
  logic               rst, din, din_valid, wr_en, commit;
  logic [1:0]         wr_addr;
  logic signed [9:0]  wr_data;
  logic               cdone, cerr, dout_valid;
  FFE_OUT_FORMAT      dout;

  // saturation instance
  logic               s_rst, s_in, s_valid, s_wr_en, s_commit;
  logic [1:0]         s_wr_addr;
  logic signed [9:0]  s_wr_data;
  logic               s_cdone, s_cerr, s_out_valid;
  logic signed [9:0]  s_out;

  tx_ffe dut (
    .clk(clk), .rst(rst), .in(din), .in_valid(din_valid),
    .coeff_wr_en(wr_en), .coeff_wr_addr(wr_addr), .coeff_wr_data(wr_data),
    .coeff_commit(commit), .commit_done(cdone), .coeff_err(cerr),
    .out(dout), .out_valid(dout_valid)
  );

  tx_ffe #(.OUT_WIDTH(10)) dut_sat (
    .clk(clk), .rst(s_rst), .in(s_in), .in_valid(s_valid),
    .coeff_wr_en(s_wr_en), .coeff_wr_addr(s_wr_addr), .coeff_wr_data(s_wr_data),
    .coeff_commit(s_commit), .commit_done(s_cdone), .coeff_err(s_cerr),
    .out(s_out), .out_valid(s_out_valid)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input int d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = 10'(d);
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = 1'b0; din_valid = 1'b0; wr_en = 1'b0; commit = 1'b0;
    wr_addr = 2'd0; wr_data = 10'sd0;
    s_rst = 1'b1; s_in = 1'b0; s_valid = 1'b0; s_wr_en = 1'b0; s_commit = 1'b0;
    s_wr_addr = 2'd0; s_wr_data = 10'sd0;
    tick();
    tick();
    chk("rst_out", dout, 0);
    chk("rst_out_valid", dout_valid, 0);
    chk("rst_commit_done", cdone, 0);
    chk("rst_coeff_err", cerr, 0);
    rst = 1'b0;
    s_rst = 1'b0;

    // zero taps: isolated symbol latency, then back-to-back
    din = 1'b1; din_valid = 1'b1;
    tick();
    chk("lat_accept_edge", dout_valid, 0);
    din_valid = 1'b0;
    tick();
    chk("lat_valid", dout_valid, 1);
    chk("lat_out", dout, 0);
    tick();
    chk("lat_valid_drop", dout_valid, 0);
    din_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i > 0) begin
        chk("b2b_valid", dout_valid, 1);
        chk("b2b_out", dout, 0);
      end
    end
    din_valid = 1'b0;
    tick();
    chk("b2b_last_valid", dout_valid, 1);
    chk("b2b_last_out", dout, 0);
    tick();
    chk("b2b_valid_end", dout_valid, 0);

    // taps 200,-60,-20 from clean history, bits 1,1,1,0
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(2'd0, 200);
    wr(2'd1, -60);
    wr(2'd2, -20);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("pend_no_done", cdone, 0);
    din_valid = 1'b1; din = 1'b1;
    tick();
    chk("t2_commit_done", cdone, 1);
    chk("t2_valid_early", dout_valid, 0);
    tick();
    chk("t2_done_pulse", cdone, 0);
    chk("t2_out0", dout, 280);
    tick();
    chk("t2_out1", dout, 160);
    din = 1'b0;
    tick();
    chk("t2_out2", dout, 120);
    din_valid = 1'b0;
    tick();
    chk("t2_out3", dout, -280);
    chk("t2_out3_valid", dout_valid, 1);
    tick();
    chk("t2_hold_valid", dout_valid, 0);
    chk("t2_hold_out", dout, -280);

    // commit with no symbols for 10 cycles, then one symbol with the new taps
    wr(2'd0, 100);
    wr(2'd1, 50);
    wr(2'd2, -10);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_idle_done", cdone, 0);
      chk("t3_idle_out", dout, -280);
    end
    din_valid = 1'b1; din = 1'b1;
    tick();
    chk("t3_commit_done", cdone, 1);
    din_valid = 1'b0;
    tick();
    chk("t3_out_new", dout, 40);
    chk("t3_done_clear", cdone, 0);

    // commit in the same IDLE cycle as a symbol: that symbol keeps the old taps
    wr(2'd0, -100);
    commit = 1'b1; din_valid = 1'b1; din = 1'b0;
    tick();
    chk("t4_same_cycle_done", cdone, 0);
    commit = 1'b0; din = 1'b1;
    tick();
    chk("t4_next_done", cdone, 1);
    chk("t4_out_old", dout, -40);
    din_valid = 1'b0;
    tick();
    chk("t4_out_new", dout, -160);
    chk("t4_done_clear", cdone, 0);

    // write while pending is dropped and flagged
    wr(2'd0, 300);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    chk("t5_err_before", cerr, 0);
    wr(2'd0, -400);
    chk("t5_err_set", cerr, 1);
    din_valid = 1'b1; din = 1'b1;
    tick();
    chk("t5_commit_done", cdone, 1);
    din_valid = 1'b0;
    tick();
    chk("t5_out_prepending", dout, 360);
    tick();
    chk("t5_err_sticky", cerr, 1);

    // saturation instance: all taps 511, one dropped write to raise coeff_err
    for (int k = 0; k < 3; k++) begin
      s_wr_en = 1'b1; s_wr_addr = 2'(k); s_wr_data = 10'sd511;
      tick();
    end
    s_wr_en = 1'b0;
    s_commit = 1'b1;
    tick();
    s_commit = 1'b0;
    s_wr_en = 1'b1; s_wr_addr = 2'd0; s_wr_data = 10'sd0;
    tick();
    s_wr_en = 1'b0;
    chk("sat_err_set", s_cerr, 1);
    s_valid = 1'b1; s_in = 1'b1;
    tick();
    tick();
    chk("sat_sym1", s_out, -511);
    tick();
    chk("sat_sym2", s_out, 511);
    s_in = 1'b0;
    tick();
    chk("sat_all_ones", s_out, 511);
    tick();
    chk("sat_sym4", s_out, 511);
    tick();
    chk("sat_sym5", s_out, -511);
    tick();
    chk("sat_all_zeros", s_out, -512);
    chk("sat_stream_valid", s_out_valid, 1);
    s_rst = 1'b1;
    tick();
    chk("sat_rst_out", s_out, 0);
    chk("sat_rst_valid", s_out_valid, 0);
    chk("sat_rst_err", s_cerr, 0);
    chk("sat_rst_done", s_cdone, 0);
    s_rst = 1'b0; s_valid = 1'b0;
    tick();
    chk("sat_rst_flush", s_out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
